// File: rtl/tilemap_read_arbiter_pkg.sv
// Shared tilemap constants: geometry, tile code width and the code returned
// for reads that fall outside the map.
package tilemap_pkg;

    localparam int TILEMAP_ADDR_W = 15;
    localparam int TILE_W         = 3;
    localparam int TILEMAP_WORDS  = 30000;

    typedef logic [TILE_W-1:0]         tile_t;
    typedef logic [TILEMAP_ADDR_W-1:0] tile_addr_t;

    localparam tile_t TILE_EMPTY = 3'b000;
    // Out-of-map reads behave as solid wall tiles.
    localparam tile_t OOB_TILE   = 3'b001;

    function automatic logic addr_in_map(input tile_addr_t addr);
        return {1'b0, addr} < (TILEMAP_ADDR_W + 1)'(TILEMAP_WORDS);
    endfunction

endpackage

// File: rtl/tilemap_read_arbiter_if.sv
// Requester-side and memory-side signals of the tilemap read arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface tilemap_read_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 3
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         mem_address;
    logic                      mem_rden;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      busy;

    modport slave (
        input  req, req_addr, mem_rdata,
        output gnt, rvalid, rdata, mem_address, mem_rden, busy
    );

    modport master (
        output req, req_addr, mem_rdata,
        input  gnt, rvalid, rdata, mem_address, mem_rden, busy
    );
endinterface

// File: rtl/tilemap_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i wins.
// Produces a one-hot grant, its encoded index and a grant-valid flag.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    int cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/tilemap_read_arbiter.sv
// Shares the single tilemap read port among NUM_REQ requesters with round-robin
// issue and routes each fixed-latency return back to the requester that issued it.
module tilemap_read_arbiter
    import tilemap_pkg::*;
#(
    parameter int                NUM_REQ       = 3,
    parameter int                ADDR_W        = tilemap_pkg::TILEMAP_ADDR_W,
    parameter int                DATA_W        = tilemap_pkg::TILE_W,
    parameter int                READ_LATENCY  = 1,
    parameter int                TILEMAP_WORDS = tilemap_pkg::TILEMAP_WORDS,
    parameter logic [DATA_W-1:0] OOB_DATA      = DATA_W'(tilemap_pkg::OOB_TILE)
) (
    input  logic                  clock,
    input  logic                  reset,
    tilemap_read_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] req_live;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               issue;
    logic [ADDR_W-1:0]  sel_addr;
    logic               in_map;

    logic [READ_LATENCY-1:0] valid_q;
    logic [READ_LATENCY-1:0] oob_q;
    logic [IDX_W-1:0]        id_q [READ_LATENCY];

    // Nothing may be granted while reset is held, so requests are masked here.
    assign req_live = bus.req & {NUM_REQ{~reset}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i   (req_live),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (issue)
    );

    assign sel_addr = bus.req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
    assign in_map   = {1'b0, sel_addr} < (ADDR_W + 1)'(TILEMAP_WORDS);

    assign bus.gnt         = arb_gnt;
    assign bus.mem_address = issue ? sel_addr : '0;
    assign bus.mem_rden    = issue & in_map;
    assign bus.busy        = (|req_live) | (|valid_q);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (issue) begin
            rr_ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Return tags travel alongside the memory access; stage READ_LATENCY-1 lines
    // up with mem_rdata for the read issued READ_LATENCY cycles earlier.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            oob_q   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= issue;
            oob_q[0]   <= issue & ~in_map;
            id_q[0]    <= arb_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                oob_q[i]   <= oob_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    always_comb begin
        bus.rvalid = '0;
        bus.rdata  = '0;
        if (valid_q[READ_LATENCY-1]) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                bus.rvalid[i] = (id_q[READ_LATENCY-1] == IDX_W'(i));
            end
            bus.rdata = oob_q[READ_LATENCY-1] ? OOB_DATA : bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_tilemap_read_arbiter.sv
// Drives three arbiter instances (latency 1, 3 and 2) with shared directed
// stimulus; per-instance scoreboards check every returned word and its timing.
module tb_tilemap_read_arbiter;

    localparam int NR = 3;
    localparam int AW = 15;
    localparam int DW = 3;

    typedef struct {
        int         port;
        logic [2:0] data;
        int         cycle;
    } exp_t;

    logic            clock;
    logic            reset;
    logic [NR-1:0]   reqDrv;
    logic [NR*AW-1:0] addrDrv;
    logic [2:0]      mem [0:32767];
    int              cycle;
    int              compared;
    int              mismatched;
    exp_t            sbQ [3][$];

    logic [NR-1:0] gntW    [3];
    logic [NR-1:0] rvalidW [3];
    logic [DW-1:0] rdataW  [3];
    logic [AW-1:0] maddrW  [3];
    logic          rdenW   [3];
    logic          busyW   [3];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    function automatic int latOf(input int g);
        return (g == 0) ? 1 : (g == 1) ? 3 : 2;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gDut
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 2;

        tilemap_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

        logic [AW-1:0] aPipe [L];
        logic          vPipe [L];

        assign bus.req      = reqDrv;
        assign bus.req_addr = addrDrv;
        assign bus.mem_rdata = vPipe[L-1] ? mem[aPipe[L-1]] : 3'b111;

        assign gntW[g]    = bus.gnt;
        assign rvalidW[g] = bus.rvalid;
        assign rdataW[g]  = bus.rdata;
        assign maddrW[g]  = bus.mem_address;
        assign rdenW[g]   = bus.mem_rden;
        assign busyW[g]   = bus.busy;

        tilemap_read_arbiter #(
            .NUM_REQ       (NR),
            .ADDR_W        (AW),
            .DATA_W        (DW),
            .READ_LATENCY  (L),
            .TILEMAP_WORDS (30000),
            .OOB_DATA      (3'b001)
        ) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        // Memory model: fixed-latency read, returns 3'b111 when no read strobe.
        always @(posedge clock) begin
            aPipe[0] <= bus.mem_address;
            vPipe[0] <= bus.mem_rden;
            for (int i = 1; i < L; i++) begin
                aPipe[i] <= aPipe[i-1];
                vPipe[i] <= vPipe[i-1];
            end
        end

        // Monitor: any rvalid, or an expected return whose cycle has come, is checked.
        always @(negedge clock) begin
            exp_t e;
            if (!reset && (bus.rvalid != '0 || (sbQ[g].size() > 0 && sbQ[g][0].cycle <= cycle))) begin
                compared++;
                if (sbQ[g].size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL ret%0d unexpected: rvalid=%b rdata=%0d at cycle %0d", g, bus.rvalid, bus.rdata, cycle);
                end else begin
                    e = sbQ[g].pop_front();
                    if (bus.rvalid != NR'(1 << e.port) || bus.rdata != e.data || cycle != e.cycle) begin
                        mismatched++;
                        $display("[TB] FAIL ret%0d: got rvalid=%b rdata=%0d cycle=%0d, want rvalid=%b rdata=%0d cycle=%0d",
                                 g, bus.rvalid, bus.rdata, cycle, NR'(1 << e.port), e.data, e.cycle);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h at cycle %0d", name, actual, expected, cycle);
        end
    endtask

    function automatic int portOf(input logic [2:0] oh);
        return oh[0] ? 0 : oh[1] ? 1 : 2;
    endfunction

    // One issue cycle: drive, then check grant/issue and queue the expected return.
    task automatic applyStimulus(input logic [2:0] r, input logic [14:0] a0, input logic [14:0] a1,
                                 input logic [14:0] a2, input logic [2:0] expGnt,
                                 input logic [14:0] expAddr, input logic expRden, input logic [2:0] expData);
        exp_t e;
        @(posedge clock);
        #1;
        reqDrv  = r;
        addrDrv = {a2, a1, a0};
        @(negedge clock);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("gnt%0d", g), 32'(gntW[g]), 32'(expGnt));
            if (r != 3'b000) checkOutput($sformatf("busy%0d", g), 32'(busyW[g]), 32'd1);
            if (expGnt != 3'b000) begin
                checkOutput($sformatf("rden%0d", g), 32'(rdenW[g]), 32'(expRden));
                checkOutput($sformatf("maddr%0d", g), 32'(maddrW[g]), 32'(expAddr));
                e.port  = portOf(expGnt);
                e.data  = expData;
                e.cycle = cycle + latOf(g);
                sbQ[g].push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            reqDrv = '0;
        end
    endtask

    task automatic resetDut(input bit holdReq);
        @(posedge clock);
        #1;
        reset = 1'b1;
        if (!holdReq) reqDrv = '0;
        for (int g = 0; g < 3; g++) sbQ[g].delete();
        @(negedge clock);
        for (int g = 0; g < 3; g++) begin
            checkOutput($sformatf("rst_gnt%0d", g), 32'(gntW[g]), 32'd0);
            checkOutput($sformatf("rst_rvalid%0d", g), 32'(rvalidW[g]), 32'd0);
            checkOutput($sformatf("rst_rdata%0d", g), 32'(rdataW[g]), 32'd0);
            checkOutput($sformatf("rst_rden%0d", g), 32'(rdenW[g]), 32'd0);
            checkOutput($sformatf("rst_maddr%0d", g), 32'(maddrW[g]), 32'd0);
            checkOutput($sformatf("rst_busy%0d", g), 32'(busyW[g]), 32'd0);
        end
        @(posedge clock);
        #1;
        reset  = 1'b0;
        reqDrv = '0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((sbQ[0].size() + sbQ[1].size() + sbQ[2].size()) != 0 && budget < 20) begin
            @(posedge clock);
            budget++;
        end
        @(negedge clock);
        for (int g = 0; g < 3; g++) checkOutput($sformatf("drained%0d", g), 32'(sbQ[g].size()), 32'd0);
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) mem[a] = 3'd3;
        mem[5]   = 3'd2;
        mem[20]  = 3'd5;  mem[21]  = 3'd6;  mem[22]  = 3'd0;
        mem[29999] = 3'd6;
        mem[100] = 3'd0;  mem[101] = 3'd4;  mem[102] = 3'd7;
        mem[200] = 3'd5;  mem[201] = 3'd6;  mem[202] = 3'd7;  mem[203] = 3'd1;
        cycle      = 0;
        compared   = 0;
        mismatched = 0;
        reset   = 1'b1;
        reqDrv  = '0;
        addrDrv = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Single requester, word 5 holds 2.
        resetDut(1'b0);
        applyStimulus(3'b001, 15'd5, 15'd0, 15'd0, 3'b001, 15'd5, 1'b1, 3'd2);
        idle(1);
        drain();

        // All requesters busy: strict rotation starting at port 0.
        resetDut(1'b0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(3'b111, 15'd20, 15'd21, 15'd22, 3'b001, 15'd20, 1'b1, 3'd5);
            applyStimulus(3'b111, 15'd20, 15'd21, 15'd22, 3'b010, 15'd21, 1'b1, 3'd6);
            applyStimulus(3'b111, 15'd20, 15'd21, 15'd22, 3'b100, 15'd22, 1'b1, 3'd0);
        end
        idle(1);
        drain();

        // Out-of-map addresses never strobe memory and read back as walls.
        applyStimulus(3'b010, 15'd0, 15'h7FFF, 15'd0, 3'b010, 15'h7FFF, 1'b0, 3'b001);
        idle(1);
        applyStimulus(3'b010, 15'd0, 15'd30000, 15'd0, 3'b010, 15'd30000, 1'b0, 3'b001);
        applyStimulus(3'b010, 15'd0, 15'd29999, 15'd0, 3'b010, 15'd29999, 1'b1, 3'd6);
        idle(1);
        drain();

        // Back-to-back reads from port 0 at words holding 0, 4, 7.
        applyStimulus(3'b001, 15'd100, 15'd0, 15'd0, 3'b001, 15'd100, 1'b1, 3'd0);
        applyStimulus(3'b001, 15'd101, 15'd0, 15'd0, 3'b001, 15'd101, 1'b1, 3'd4);
        applyStimulus(3'b001, 15'd102, 15'd0, 15'd0, 3'b001, 15'd102, 1'b1, 3'd7);
        idle(1);
        drain();

        // Only port 2: grant every cycle, busy until each instance's last return.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(3'b100, 15'd0, 15'd0, 15'(200 + k), 3'b100, 15'(200 + k), 1'b1, mem[200 + k]);
        end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            #1;
            reqDrv = '0;
            @(negedge clock);
            for (int g = 0; g < 3; g++) begin
                checkOutput($sformatf("busy%0d_tail%0d", g, k), 32'(busyW[g]), 32'(k <= latOf(g)));
            end
        end
        drain();

        // Reset one cycle after a grant discards the read and restarts rotation.
        applyStimulus(3'b010, 15'd0, 15'd21, 15'd0, 3'b010, 15'd21, 1'b1, 3'd6);
        resetDut(1'b1);
        idle(4);
        applyStimulus(3'b111, 15'd20, 15'd21, 15'd22, 3'b001, 15'd20, 1'b1, 3'd5);
        idle(1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
